// File: rtl/serial_shift_pkg.sv
// Shared types and default sizing for the serial shift controller.
package serial_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/serial_shift_ctrl.sv
// Serialises a word MSB-first through an external DEPTH-stage SISO chain and reassembles it from so.
// Result valid WIDTH+DEPTH+1 cycles after accept, held until out_ready; optional SHIFT_LOOPBACK_CHK_EN flags mismatch on err.
module serial_shift_ctrl
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             si,
  input  logic             so,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] TX_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] RX_FIRST = CW'(DEPTH);
  localparam logic [CW-1:0] RX_LAST  = CW'(WIDTH + DEPTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] rx_next;

  assign rx_next = (rx_sr << 1) | WIDTH'(so);

  // cnt = cycles since accept minus one; so is only trusted once cnt reaches DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      si        <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_SHIFT;
            cnt      <= '0;
            si       <= in_data[WIDTH-1];
            tx_sr    <= in_data << 1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt >= RX_FIRST) rx_sr <= rx_next;
          if (cnt == TX_LAST) begin
            si    <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            si    <= tx_sr[WIDTH-1];
            tx_sr <= tx_sr << 1;
          end
        end
        ST_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt >= RX_FIRST) rx_sr <= rx_next;
          if (cnt == RX_LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= rx_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFT_LOOPBACK_CHK_EN
  // tx_sr is consumed while shifting, so the sent word needs its own copy
  logic [WIDTH-1:0] sent_word;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_word <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) sent_word <= in_data;
      if (state == ST_DRAIN && cnt == RX_LAST) err_q <= (rx_next != sent_word);
      else if (state == ST_DONE && out_ready) err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/serial_shift_ctrl.md
SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per parallel word (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, stage count of the attached SISO chain (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  parallel word offered.
REQ-006 SHALL have port in_ready  output  1  controller can accept a word.
REQ-007 SHALL have port in_data  input  WIDTH  word to transmit.
REQ-008 SHALL have port si  output  1  serial bit driven into the SISO chain.
REQ-009 SHALL have port so  input  1  serial bit returned from the SISO chain.
REQ-010 SHALL have port out_valid  output  1  received word available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts received word.
REQ-012 SHALL have port out_data  output  WIDTH  word reassembled from so.
REQ-013 SHALL have port busy  output  1  transfer in progress (state not IDLE).
REQ-014 SHALL have port err  output  1  loopback mismatch flag.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DRAIN -> DONE -> IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready at a clock edge; in_data registered at accept, later changes ignored.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, driving si MSB-first, one bit per cycle, starting the cycle after accept.
REQ-018 si SHALL be 0 in every state other than SHIFT.
REQ-019 Bit driven in cycle c SHALL be sampled from so at the end of cycle c+DEPTH; so in the first DEPTH cycles after accept SHALL be ignored (stale chain contents).
REQ-020 DRAIN SHALL last exactly DEPTH cycles; out_data assembled MSB-first from the WIDTH sampled bits.
REQ-021 out_valid SHALL rise WIDTH+DEPTH+1 cycles after the accept edge (13 at defaults) and stay high with out_data/err stable until out_valid && out_ready.
REQ-022 Output handshake in DONE SHALL return to IDLE next cycle; in_ready rises that cycle, so back-to-back word spacing is WIDTH+DEPTH+2 cycles minimum.
REQ-023 in_valid while not IDLE SHALL be ignored with no state change.
REQ-024 Shift/bit counter SHALL be $clog2(WIDTH+DEPTH+1) bits wide, no wrap within a transfer.

Reset
REQ-025 rst SHALL force, at the next edge, state IDLE, in_ready=1, si=0, out_valid=0, out_data=0, busy=0, err=0, counter=0.
REQ-026 rst mid-transfer SHALL discard the partial word; no out_valid for it; next accepted word transfers normally.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-028 Macro SHIFT_LOOPBACK_CHK_EN defined: err SHALL be set with out_valid when out_data != registered in_data, cleared with out_valid.
REQ-029 Macro undefined: err SHALL be constant 0, no comparator or copy register synthesized; all other behaviour identical.

Structure
REQ-030 Package serial_shift_pkg SHALL hold the state enum type and default WIDTH/DEPTH constants.
REQ-031 No sub-module; FSM, counter, transmit and receive shift registers inline in serial_shift_ctrl.

Verification (WIDTH=8, DEPTH=4, looped through a 4-stage SISO)
REQ-032 Reset held 2 cycles -> in_ready=1, busy=0, out_valid=0, si=0, err=0.
REQ-033 Send 0xA5 -> si = 1,0,1,0,0,1,0,1 in cycles 1-8; out_valid in cycle 13, out_data=0xA5, err=0.
REQ-034 0x3C accepted, out_ready low 5 cycles -> out_valid/out_data stable, in_ready=0; handshake -> in_ready=1 next cycle.
REQ-035 in_valid with 0xFF during busy, and in_data changed mid-SHIFT -> ignored; received word equals first accepted word.
REQ-036 rst asserted in cycle 6 of a 0x81 transfer -> IDLE next cycle, no out_valid; then 0x0F -> out_data=0x0F.
REQ-037 so forced 0, send 0xFF -> out_data=0x00; err=1 with SHIFT_LOOPBACK_CHK_EN, err=0 without.
